return_stack: RTL and testbench
===============================

Name: return_stack

Overview:
- Parametrised hardware return-address stack; successor to the CPU's single-entry Stack register.
- Supports nested CALL/RET up to DEPTH levels.
- Sits between PC output (push data) and MUX_PC return-address input (data_o); driven by SequenceControl push/pop strobes.
- Reports fill level plus sticky overflow/underflow errors for halt/debug.

Parameters:
DATA_WIDTH, 16, width of each stored return address
DEPTH, 8, number of entries; power of two, >= 2
PTR_WIDTH, $clog2(DEPTH), pointer width (derived localparam, not overridable)

Ports:
clk_i  input  1  clock, rising edge
reset_ni  input  1  asynchronous active-low reset
clr_ni  input  1  synchronous active-low clear: empties stack, clears sticky flags
push_ni  input  1  active-low push strobe; writes data_i at the edge
pop_ni  input  1  active-low pop strobe; removes top entry at the edge
data_i  input  DATA_WIDTH  value to push (PC, already at next address)
data_o  output  DATA_WIDTH  current top-of-stack; 0 when empty
count_o  output  PTR_WIDTH+1  number of valid entries, 0..DEPTH
empty_o  output  1  count_o == 0
full_o  output  1  count_o == DEPTH
overflow_o  output  1  sticky: push attempted while full
underflow_o  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (async, reset_ni=0): count=0, top pointer=0, overflow_o=0, underflow_o=0, data_o=0, empty_o=1, full_o=0. Storage array is not reset.
- Priority at each edge: reset > clr_ni > push/pop.
- clr_ni=0 at an edge: same state as reset except storage. Concurrent push/pop are ignored.
- Storage is a circular array of DEPTH entries.
  - top pointer addresses the most recent entry.
  - count is tracked separately so full and empty are unambiguous.
- Push only (count<DEPTH): pointer += 1 mod DEPTH; entry[pointer] <= data_i; count += 1.
- Pop only (count>0): pointer -= 1 mod DEPTH; count -= 1. Entry contents are left in place.
- Push+pop same edge with count>0: replace the top entry with data_i. Pointer and count are unchanged.
- Push+pop same edge with count==0: treated as push only; underflow_o is not set.
- Pop with count==0: no state change; underflow_o <= 1.
- Push with count==DEPTH: governed by the optional feature.
- Latency:
  - data_o, count_o, empty_o and full_o reflect the new state immediately after the edge that applied push/pop (zero extra cycles).
  - data_o is a combinational read of entry[pointer], gated to 0 when empty.
- Sticky flags stay at 1 until reset or clr_ni.
- Mid-operation async reset discards all contents. The next pop after reset underflows.

Optional Feature:
Macro RSTACK_WRAP_EN.
- Defined: push when full overwrites the oldest entry.
  - pointer += 1 mod DEPTH; entry written; count stays DEPTH; overflow_o <= 1.
  - The newest DEPTH return addresses are retained, which suits deep recursion that never unwinds fully.
- Undefined: push when full is dropped.
  - No write, pointer and count unchanged; overflow_o <= 1.
  - data_o keeps the previous top.

Decomposition:
- constants.v gains RSTACK_DEPTH_DEFAULT and the CALL/RET opcode constants that SequenceControl decodes into push_ni/pop_ni.
- PTR_WIDTH is a local derived parameter, not shared.
- One sub-module: rstack_storage.
  - DEPTH x DATA_WIDTH register array.
  - One synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
  - No reset.
- Pointer, count and flag logic stays in return_stack.

Test Plan (DEPTH=4, DATA_WIDTH=16):
- Reset then push 0x0011, 0x0022, 0x0033 -> count_o=3, data_o=0x0033; three pops return 0x0033, 0x0022, 0x0011, then empty_o=1 and data_o=0.
- Pop on empty -> underflow_o=1, count_o=0; flag persists through a later push of 0x0044; clr_ni pulse -> underflow_o=0, count_o=0.
- Push 0x1..0x4 then push 0x5, without RSTACK_WRAP_EN -> full_o=1, overflow_o=1, data_o=0x0004; popping 4 times yields 4,3,2,1.
- Same stimulus with RSTACK_WRAP_EN -> data_o=0x0005, count_o=4, overflow_o=1; popping 4 times yields 5,4,3,2.
- count=2 (top 0x00A0), simultaneous push 0x00B0 + pop -> count_o=2, data_o=0x00B0; pop -> data_o = previous lower entry.
- Assert reset_ni asynchronously mid-cycle with count=3 -> outputs at reset values before the next clock edge; subsequent pop sets underflow_o=1.

Source files
------------

// File: rtl/return_stack_pkg.sv
// Shared constants and types for the hardware return-address stack.
package return_stack_pkg;

  localparam int RSTACK_DEPTH_DEFAULT = 8;

  // CALL/RET opcodes decoded by SequenceControl into push_ni/pop_ni.
  localparam logic [3:0] OPC_CALL = 4'hC;
  localparam logic [3:0] OPC_RET  = 4'hD;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } stack_op_e;

endpackage

// File: rtl/rstack_storage.sv
// Return-stack entry array: one synchronous write port, one asynchronous read port, no reset.
module rstack_storage #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/return_stack.sv
// Parametrised return-address stack with sticky overflow/underflow flags.
// Define RSTACK_WRAP_EN to make a push while full overwrite the oldest entry.
module return_stack
  import return_stack_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = RSTACK_DEPTH_DEFAULT
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    clr_ni,
  input  logic                    push_ni,
  input  logic                    pop_ni,
  input  logic [DATA_WIDTH-1:0]   data_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    empty_o,
  output logic                    full_o,
  output logic                    overflow_o,
  output logic                    underflow_o
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1);
  localparam logic [PTR_WIDTH:0]   CNT_ONE    = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH:0]   FULL_COUNT = (PTR_WIDTH+1)'(DEPTH);

  logic [PTR_WIDTH-1:0]  ptr, ptr_next, waddr;
  logic [PTR_WIDTH:0]    count, count_next;
  logic                  ovf, ovf_next, unf, unf_next;
  logic                  we, empty, full;
  logic [DATA_WIDTH-1:0] rdata;
  stack_op_e             op;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  // Push+pop on an empty stack degrades to a plain push so it never underflows.
  always_comb begin
    op = OP_NONE;
    case ({push_ni, pop_ni})
      2'b01:   op = OP_PUSH;
      2'b10:   op = OP_POP;
      2'b00:   op = empty ? OP_PUSH : OP_REPLACE;
      default: op = OP_NONE;
    endcase
  end

  always_comb begin
    ptr_next   = ptr;
    count_next = count;
    ovf_next   = ovf;
    unf_next   = unf;
    we         = 1'b0;
    waddr      = ptr;
    if (!clr_ni) begin
      ptr_next   = '0;
      count_next = '0;
      ovf_next   = 1'b0;
      unf_next   = 1'b0;
    end else begin
      case (op)
        OP_REPLACE: we = 1'b1;
        OP_PUSH: begin
          if (!full) begin
            ptr_next   = ptr + PTR_ONE;
            waddr      = ptr + PTR_ONE;
            we         = 1'b1;
            count_next = count + CNT_ONE;
          end else begin
            ovf_next = 1'b1;
`ifdef RSTACK_WRAP_EN
            ptr_next = ptr + PTR_ONE;
            waddr    = ptr + PTR_ONE;
            we       = 1'b1;
`endif
          end
        end
        OP_POP: begin
          if (!empty) begin
            ptr_next   = ptr - PTR_ONE;
            count_next = count - CNT_ONE;
          end else begin
            unf_next = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ptr   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      ptr   <= ptr_next;
      count <= count_next;
      ovf   <= ovf_next;
      unf   <= unf_next;
    end
  end

  rstack_storage #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(PTR_WIDTH)
  ) u_storage (
    .clk  (clk_i),
    .we   (we && reset_ni),
    .waddr(waddr),
    .wdata(data_i),
    .raddr(ptr),
    .rdata(rdata)
  );

  assign data_o      = empty ? '0 : rdata;
  assign count_o     = count;
  assign empty_o     = empty;
  assign full_o      = full;
  assign overflow_o  = ovf;
  assign underflow_o = unf;

endmodule

// File: tb/tb_return_stack.sv
// Self-checking bench for return_stack (DEPTH=4) against a queue-based reference model.
module tb_return_stack;

  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_ni, clr_ni, push_ni, pop_ni;
  logic [DW-1:0] data_i, data_o;
  logic [2:0]    count_o;
  logic          empty_o, full_o, overflow_o, underflow_o;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] model_q[$];
  bit            model_ovf, model_unf;

  always #5 clk = ~clk;

  return_stack #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk_i      (clk),
    .reset_ni   (reset_ni),
    .clr_ni     (clr_ni),
    .push_ni    (push_ni),
    .pop_ni     (pop_ni),
    .data_i     (data_i),
    .data_o     (data_o),
    .count_o    (count_o),
    .empty_o    (empty_o),
    .full_o     (full_o),
    .overflow_o (overflow_o),
    .underflow_o(underflow_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    model_ovf = 1'b0;
    model_unf = 1'b0;
  endtask

  // Stack semantics: the back of the queue is the top of stack.
  task automatic model_apply(input bit push, input bit pop, input bit clr, input logic [DW-1:0] d);
    if (clr) model_reset();
    else if (push && pop) begin
      if (model_q.size() > 0) model_q[model_q.size()-1] = d;
      else model_q.push_back(d);
    end else if (push) begin
      if (model_q.size() < DEPTH) model_q.push_back(d);
      else begin
        model_ovf = 1'b1;
`ifdef RSTACK_WRAP_EN
        void'(model_q.pop_front());
        model_q.push_back(d);
`endif
      end
    end else if (pop) begin
      if (model_q.size() > 0) void'(model_q.pop_back());
      else model_unf = 1'b1;
    end
  endtask

  task automatic check_state(input string tag);
    int unsigned n;
    logic [DW-1:0] top;
    n   = model_q.size();
    top = (n > 0) ? model_q[n-1] : '0;
    chk({tag, ".data"},  32'(data_o),      32'(top));
    chk({tag, ".count"}, 32'(count_o),     32'(n));
    chk({tag, ".empty"}, 32'(empty_o),     32'(n == 0));
    chk({tag, ".full"},  32'(full_o),      32'(n == DEPTH));
    chk({tag, ".ovf"},   32'(overflow_o),  32'(model_ovf));
    chk({tag, ".unf"},   32'(underflow_o), 32'(model_unf));
  endtask

  task automatic step(input bit push, input bit pop, input bit clr, input logic [DW-1:0] d,
                      input string tag);
    @(negedge clk);
    push_ni = !push;
    pop_ni  = !pop;
    clr_ni  = !clr;
    data_i  = d;
    @(posedge clk);
    #1;
    model_apply(push, pop, clr, d);
    check_state(tag);
  endtask

  initial begin
    reset_ni = 1'b0;
    clr_ni   = 1'b1;
    push_ni  = 1'b1;
    pop_ni   = 1'b1;
    data_i   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    @(negedge clk);
    reset_ni = 1'b1;

    // Basic LIFO order
    step(1, 0, 0, 16'h0011, "push1");
    step(1, 0, 0, 16'h0022, "push2");
    step(1, 0, 0, 16'h0033, "push3");
    chk("lifo.top", 32'(data_o), 32'h0033);
    step(0, 1, 0, '0, "pop1");
    chk("lifo.after_pop1", 32'(data_o), 32'h0022);
    step(0, 1, 0, '0, "pop2");
    step(0, 1, 0, '0, "pop3");
    chk("lifo.empty_data", 32'(data_o), 32'h0);

    // Underflow is sticky until clear
    step(0, 1, 0, '0, "pop_empty");
    chk("unf.set", 32'(underflow_o), 32'h1);
    step(1, 0, 0, 16'h0044, "push_after_unf");
    step(0, 0, 1, '0, "clr1");
    chk("unf.cleared", 32'(underflow_o), 32'h0);

    // Overflow behaviour at DEPTH
    for (int i = 1; i <= 5; i++) step(1, 0, 0, DW'(i), "fill");
    chk("ovf.full", 32'(full_o), 32'h1);
    chk("ovf.set", 32'(overflow_o), 32'h1);
`ifdef RSTACK_WRAP_EN
    chk("ovf.top", 32'(data_o), 32'h0005);
`else
    chk("ovf.top", 32'(data_o), 32'h0004);
`endif
    for (int i = 0; i < 4; i++) step(0, 1, 0, '0, "drain");
    step(0, 0, 1, '0, "clr2");

    // Simultaneous push+pop replaces the top; on empty it is a plain push
    step(1, 0, 0, 16'h0090, "rep.push_a");
    step(1, 0, 0, 16'h00A0, "rep.push_b");
    step(1, 1, 0, 16'h00B0, "rep.replace");
    chk("rep.top", 32'(data_o), 32'h00B0);
    step(0, 1, 0, '0, "rep.pop");
    chk("rep.lower", 32'(data_o), 32'h0090);
    step(0, 1, 0, '0, "rep.pop_last");
    step(1, 1, 0, 16'h00C0, "rep.on_empty");
    chk("rep.on_empty_unf", 32'(underflow_o), 32'h0);

    // Asynchronous reset mid-cycle with count=3
    step(1, 0, 0, 16'h0123, "ar.push1");
    step(1, 0, 0, 16'h0456, "ar.push2");
    @(negedge clk);
    push_ni = 1'b1;
    pop_ni  = 1'b1;
    #2;
    reset_ni = 1'b0;
    #1;
    model_reset();
    check_state("async_reset");
    @(negedge clk);
    reset_ni = 1'b1;
    step(0, 1, 0, '0, "ar.pop_after");
    chk("ar.unf", 32'(underflow_o), 32'h1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit push, pop, clr;
      push = ($urandom_range(0, 99) < 55);
      pop  = ($urandom_range(0, 99) < 45);
      clr  = ($urandom_range(0, 31) == 0);
      step(push, pop, clr, DW'($urandom), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
